// File: rtl/apb_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_arb_pkg                                                        |
// | Shared types and helpers for the APB master arbiter.               |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package apb_arb_pkg;

   // Sequencer states: waiting for a request, APB setup phase, APB access phase.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } arb_state_t;

   // Width of a counter that must hold values 0..t, never narrower than 1 bit.
   function automatic int cnt_width(input int t);
      return (t < 1) ? 1 : $clog2(t + 1);
   endfunction

endpackage : apb_arb_pkg
`default_nettype wire

// File: rtl/apb_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_rr_pick                                                        |
// | Combinational round-robin picker: first requester above last_grant |
// | (with wrap-around) wins.                                           |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module apb_rr_pick #(
   parameter int  NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] gnt_onehot,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               any
);

   int               cand;
   logic [IDX_W-1:0] cand_idx;

   // Scan from last_grant+1 upward; the previous winner is visited last.
   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      any        = 1'b0;
      cand       = 0;
      cand_idx   = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = int'(last_grant) + off;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IDX_W'(cand);
         if (!any && req[cand_idx]) begin
            any        = 1'b1;
            gnt_idx    = cand_idx;
            gnt_onehot = NUM_REQ'(1) << cand_idx;
         end
      end
   end

endmodule : apb_rr_pick
`default_nettype wire

// File: rtl/apb_master_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_master_arb                                                     |
// | Round-robin arbiter in front of a single APB master port, with     |
// | PREADY timeout and one-cycle response pulse per transfer.          |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module apb_master_arb
   import apb_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int APB_ADDR_WIDTH = 16,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                               PCLK,
   input  logic                               PRESETn,
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [NUM_REQ-1:0]                 req_write,
   input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]                 req_ready,
   output logic [NUM_REQ-1:0]                 rsp_valid,
   output logic [APB_DATA_WIDTH-1:0]          rsp_rdata,
   output logic                               rsp_err,
   output logic [APB_ADDR_WIDTH-1:0]          PADDR,
   output logic                               PWRITE,
   output logic [APB_DATA_WIDTH-1:0]          PWDATA,
   output logic                               PSEL,
   output logic                               PENABLE,
   input  logic                               PREADY,
   input  logic [APB_DATA_WIDTH-1:0]          PRDATA,
   input  logic                               PSLVERR
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

   arb_state_t           state;
   logic [IDX_W-1:0]     last_grant;   // also the owner of the transfer in flight
   logic [CNT_W-1:0]     wait_cnt;

   logic [NUM_REQ-1:0]   pick_onehot;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_any;
   logic                 timed_out;

   apb_rr_pick #(
      .NUM_REQ    (NUM_REQ)
   ) u_pick (
      .req        (req_valid),
      .last_grant (last_grant),
      .gnt_onehot (pick_onehot),
      .gnt_idx    (pick_idx),
      .any        (pick_any)
   );

   // A grant is only offered while the bus is free.
   always_comb begin
      req_ready = '0;
      if (state == IDLE && pick_any) begin
         req_ready = pick_onehot;
      end
   end

   // Timeout fires when the counter has reached the limit and the slave is still stalling.
   always_comb begin
      timed_out = 1'b0;
      if (TIMEOUT_CYCLES != 0 && wait_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
         timed_out = 1'b1;
      end
   end

   // Sequencer: grant, APB setup/access phases and registered response pulse.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state      <= IDLE;
         last_grant <= IDX_W'(NUM_REQ - 1);
         wait_cnt   <= '0;
         PADDR      <= '0;
         PWRITE     <= 1'b0;
         PWDATA     <= '0;
         PSEL       <= 1'b0;
         PENABLE    <= 1'b0;
         rsp_valid  <= '0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
      end else begin
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  PADDR      <= req_addr[int'(pick_idx)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                  PWDATA     <= req_wdata[int'(pick_idx)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                  PWRITE     <= req_write[pick_idx];
                  last_grant <= pick_idx;
                  PSEL       <= 1'b1;
                  state      <= SETUP;
               end
            end
            SETUP: begin
               PENABLE  <= 1'b1;
               wait_cnt <= '0;
               state    <= ACCESS;
            end
            ACCESS: begin
               if (PREADY) begin
                  rsp_valid <= NUM_REQ'(1) << last_grant;
                  rsp_rdata <= PWRITE ? '0 : PRDATA;
                  rsp_err   <= PSLVERR;
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  state     <= IDLE;
               end else if (timed_out) begin
                  // Abandon the bus; the slave gets no further PREADY wait.
                  rsp_valid <= NUM_REQ'(1) << last_grant;
                  rsp_err   <= 1'b1;
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  state     <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               PSEL    <= 1'b0;
               PENABLE <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule : apb_master_arb
`default_nettype wire
